fadd_arbiter: RTL and testbench

FADD_ARBITER -- requirements
Module: fadd_arbiter

---
 rtl/fadd_arbiter_if.sv | 36 +++
 rtl/fadd_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fadd_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared adder core.
interface fadd_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned DW = 32;

  // requester side
  logic [DW*NUM_REQ-1:0] req_a;
  logic [DW*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_stb;
  logic [NUM_REQ-1:0]    req_ack;
  logic [DW-1:0]         rsp_z;
  logic [NUM_REQ-1:0]    rsp_stb;
  logic [NUM_REQ-1:0]    rsp_ack;

  // adder core side
  logic [DW-1:0]         core_a;
  logic [DW-1:0]         core_b;
  logic                  core_in_stb;
  logic                  core_in_ack;
  logic [DW-1:0]         core_z;
  logic                  core_z_stb;
  logic                  core_z_ack;

  // arbiter view
  modport slave (
    input  req_a, req_b, req_stb, rsp_ack, core_in_ack, core_z, core_z_stb,
    output req_ack, rsp_z, rsp_stb, core_a, core_b, core_in_stb, core_z_ack
  );

  // requesters plus adder core view
  modport master (
    output req_a, req_b, req_stb, rsp_ack, core_in_ack, core_z, core_z_stb,
    input  req_ack, rsp_z, rsp_stb, core_a, core_b, core_in_stb, core_z_ack
  );
endinterface

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one single-precision adder core among NUM_REQ
// requesters; one operation outstanding at a time, all outputs registered.
module fadd_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic               clk,
  input  logic               rstnn,
  fadd_arbiter_if.slave      bus,
  output logic               busy,
  output logic [IDW-1:0]     owner,
  output logic [15:0]        op_count
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    RESPOND  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [CW-1:0]        op_count_q, op_count_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]   rsp_stb_q, rsp_stb_d;
  logic [DW-1:0]        rsp_z_q, rsp_z_d;
  logic                 core_in_stb_q, core_in_stb_d;
  logic                 core_z_ack_q, core_z_ack_d;
  logic [DW-1:0]        core_a_q, core_a_d;
  logic [DW-1:0]        core_b_q, core_b_d;
  logic                 busy_q, busy_d;

  logic                 grant_found;
  logic [IDW-1:0]       grant_idx;
  logic [DW-1:0]        op_a [NUM_REQ];
  logic [DW-1:0]        op_b [NUM_REQ];

  // Split the flat operand buses into per-requester words.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign op_a[g] = bus.req_a[DW*g +: DW];
    assign op_b[g] = bus.req_b[DW*g +: DW];
  end

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && bus.req_stb[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    op_count_d    = op_count_q;
    req_ack_d     = '0;
    rsp_stb_d     = rsp_stb_q;
    rsp_z_d       = rsp_z_q;
    core_in_stb_d = core_in_stb_q;
    core_z_ack_d  = 1'b0;
    core_a_d      = core_a_q;
    core_b_d      = core_b_q;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          core_a_d             = op_a[grant_idx];
          core_b_d             = op_b[grant_idx];
          owner_d              = grant_idx;
          req_ack_d[grant_idx] = 1'b1;
          core_in_stb_d        = 1'b1;
          ptr_d                = (32'(grant_idx) == NUM_REQ - 1) ? '0
                                                                 : grant_idx + IDW'(1);
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        // operands stay put after the handshake; the core may sample late
        if (core_in_stb_q && bus.core_in_ack) begin
          core_in_stb_d = 1'b0;
          state_d       = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (bus.core_z_stb) begin
          rsp_z_d            = bus.core_z;
          core_z_ack_d       = 1'b1;
          rsp_stb_d          = '0;
          rsp_stb_d[owner_q] = 1'b1;
          state_d            = RESPOND;
        end
      end
      RESPOND: begin
        // only the owner's ack counts; core_z_stb is not looked at here
        if (rsp_stb_q[owner_q] && bus.rsp_ack[owner_q]) begin
          rsp_stb_d  = '0;
          op_count_d = op_count_q + CW'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      op_count_q    <= '0;
      req_ack_q     <= '0;
      rsp_stb_q     <= '0;
      rsp_z_q       <= '0;
      core_in_stb_q <= 1'b0;
      core_z_ack_q  <= 1'b0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      op_count_q    <= op_count_d;
      req_ack_q     <= req_ack_d;
      rsp_stb_q     <= rsp_stb_d;
      rsp_z_q       <= rsp_z_d;
      core_in_stb_q <= core_in_stb_d;
      core_z_ack_q  <= core_z_ack_d;
      core_a_q      <= core_a_d;
      core_b_q      <= core_b_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.rsp_stb     = rsp_stb_q;
  assign bus.rsp_z       = rsp_z_q;
  assign bus.core_a      = core_a_q;
  assign bus.core_b      = core_b_q;
  assign bus.core_in_stb = core_in_stb_q;
  assign bus.core_z_ack  = core_z_ack_q;
  assign busy            = busy_q;
  assign owner           = owner_q;
  assign op_count        = op_count_q;

endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter with a small behavioural adder core and
// auto-responding requesters.
module tb_fadd_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDW     = 2;

  logic           clk;
  logic           rstnn;
  logic           busy;
  logic [IDW-1:0] owner;
  logic [15:0]    op_count;

  fadd_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  fadd_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rstnn    (rstnn),
    .bus      (bus),
    .busy     (busy),
    .owner    (owner),
    .op_count (op_count)
  );

  int errors = 0;
  int checks = 0;

  int          grants[$];
  int          long_ack   = 0;
  int          onehot_err = 0;
  int          zack_cnt   = 0;
  logic [3:0]  prev_ack   = '0;

  bit          auto_rsp    = 1'b1;
  int          core_lat    = 2;
  logic [31:0] core_result = '0;
  logic [31:0] core_a_seen = '0;
  logic [31:0] core_b_seen = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural adder core: acks the input strobe, returns core_result later.
  initial begin
    bit pend;
    int cd;
    pend = 1'b0;
    cd   = 0;
    bus.core_in_ack = 1'b0;
    bus.core_z_stb  = 1'b0;
    bus.core_z      = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstnn) begin
        bus.core_in_ack = 1'b0;
        bus.core_z_stb  = 1'b0;
        pend            = 1'b0;
      end else begin
        if (bus.core_z_stb && bus.core_z_ack) bus.core_z_stb = 1'b0;
        if (bus.core_in_ack) begin
          bus.core_in_ack = 1'b0;
          core_a_seen     = bus.core_a;
          core_b_seen     = bus.core_b;
          pend            = 1'b1;
          cd              = core_lat;
        end else if (bus.core_in_stb && !pend) begin
          bus.core_in_ack = 1'b1;
        end
        if (pend) begin
          if (cd == 0) begin
            bus.core_z     = core_result;
            bus.core_z_stb = 1'b1;
            pend           = 1'b0;
          end else begin
            cd = cd - 1;
          end
        end
      end
    end
  end

  // Requesters drop their strobe when acked and optionally take results at once.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ack[i]) bus.req_stb[i] = 1'b0;
      if (auto_rsp) bus.rsp_ack = bus.rsp_stb;
    end
  end

  // Monitor: grant order, pulse widths, one-hot outputs, core_z_ack pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rstnn) begin
        if ($countones(bus.req_ack) > 1 || $countones(bus.rsp_stb) > 1)
          onehot_err = onehot_err + 1;
        if (bus.req_ack != '0) begin
          if (bus.req_ack == prev_ack) long_ack = long_ack + 1;
          for (int i = 0; i < NUM_REQ; i++)
            if (bus.req_ack[i]) grants.push_back(i);
        end
        if (bus.core_z_ack) zack_cnt = zack_cnt + 1;
        prev_ack = bus.req_ack;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rstnn       = 1'b0;
    bus.req_stb = '0;
    bus.rsp_ack = '0;
    bus.req_a   = '0;
    bus.req_b   = '0;
    auto_rsp    = 1'b1;
    core_lat    = 2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    grants.delete();
    long_ack   = 0;
    onehot_err = 0;
    zack_cnt   = 0;
    prev_ack   = '0;
  endtask

  task automatic wait_grants(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (grants.size() >= n);
    end
  endtask

  task automatic wait_ops(input logic [15:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (op_count == target);
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = (bus.rsp_stb != '0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    checks++; if (bus.req_ack !== 4'b0) begin errors++; $display("FAIL reset_req_ack got %b want 0000", bus.req_ack); end
    checks++; if (bus.rsp_stb !== 4'b0) begin errors++; $display("FAIL reset_rsp_stb got %b want 0000", bus.rsp_stb); end
    checks++; if (bus.rsp_z !== 32'h0) begin errors++; $display("FAIL reset_rsp_z got %h want 0", bus.rsp_z); end
    checks++; if (bus.core_in_stb !== 1'b0 || bus.core_z_ack !== 1'b0) begin
      errors++; $display("FAIL reset_core_strobes got in_stb=%0b z_ack=%0b want 0 0", bus.core_in_stb, bus.core_z_ack); end
    checks++; if (bus.core_a !== 32'h0 || bus.core_b !== 32'h0) begin
      errors++; $display("FAIL reset_core_ops got a=%h b=%h want 0 0", bus.core_a, bus.core_b); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    bus.req_a[63:32] = 32'h3F80_0000;
    bus.req_b[63:32] = 32'h4000_0000;
    core_result      = 32'h4040_0000;
    bus.req_stb[1]   = 1'b1;
    wait_rsp(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_rsp_timeout got no rsp_stb want rsp_stb within 50 cycles"); end
    checks++; if (bus.rsp_stb !== 4'b0010) begin errors++; $display("FAIL single_rsp_stb got %b want 0010", bus.rsp_stb); end
    checks++; if (bus.rsp_z !== 32'h4040_0000) begin errors++; $display("FAIL single_rsp_z got %h want 40400000", bus.rsp_z); end
    checks++; if (core_a_seen !== 32'h3F80_0000 || core_b_seen !== 32'h4000_0000) begin
      errors++; $display("FAIL single_core_ops got a=%h b=%h want 3f800000 40000000", core_a_seen, core_b_seen); end
    wait_ops(16'd1, 50, ok);
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_op_count got %0d want 1", op_count); end
    checks++; if (grants.size() != 1 || grants[0] != 1) begin
      errors++; $display("FAIL single_grants got %0d grants (first %0d) want 1 grant to 1", grants.size(), grants.size() > 0 ? grants[0] : -1); end
    checks++; if (owner !== 2'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_owner_busy got owner=%0d busy=%0b want 1 0", owner, busy); end
  endtask

  task automatic test_round_robin();
    bit ok;
    bit bad;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[32*i +: 32] = 32'h1000_0000 + 32'(i);
      bus.req_b[32*i +: 32] = 32'h2000_0000 + 32'(i);
    end
    core_result = 32'h3F00_0000;
    bus.req_stb = 4'b1111;
    wait_grants(4, 200, ok);
    wait_ops(16'd4, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_ops got op_count=%0d want 4", op_count); end
    bad = (grants.size() < 4);
    for (int i = 0; i < 4 && !bad; i++) if (grants[i] != i) bad = 1'b1;
    checks++; if (bad) begin errors++; $display("FAIL rr_order got %0d grants want order 0,1,2,3", grants.size()); end
    checks++; if (core_a_seen !== 32'h1000_0003 || core_b_seen !== 32'h2000_0003) begin
      errors++; $display("FAIL rr_last_ops got a=%h b=%h want 10000003 20000003", core_a_seen, core_b_seen); end
    bus.req_stb[0] = 1'b1;
    bus.req_stb[1] = 1'b1;
    wait_grants(6, 200, ok);
    checks++; if (!ok || grants[4] != 0 || grants[5] != 1) begin
      errors++; $display("FAIL rr_wrap got %0d grants want grants 5,6 = 0,1", grants.size()); end
    checks++; if (long_ack != 0) begin errors++; $display("FAIL rr_ack_width got %0d long pulses want 0", long_ack); end
  endtask

  task automatic test_hold_priority();
    bit ok;
    do_reset();
    core_result    = 32'h4100_0000;
    bus.req_stb[2] = 1'b1;
    wait_grants(1, 50, ok);
    bus.req_stb[2] = 1'b1;
    bus.req_stb[3] = 1'b1;
    wait_grants(3, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_timeout got %0d grants want 3", grants.size()); end
    checks++; if (!ok || grants[0] != 2 || grants[1] != 3 || grants[2] != 2) begin
      errors++; $display("FAIL hold_order got %0d grants want order 2,3,2", grants.size()); end
  endtask

  task automatic test_delayed_ack();
    bit ok;
    int bad_stb;
    int bad_z;
    do_reset();
    auto_rsp       = 1'b0;
    bus.req_a[31:0] = 32'h4000_0000;
    bus.req_b[31:0] = 32'h4040_0000;
    bus.req_a[63:32] = 32'h3F80_0000;
    bus.req_b[63:32] = 32'h3F80_0000;
    core_result    = 32'h40A0_0000;
    bus.req_stb[0] = 1'b1;
    wait_rsp(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL delay_rsp_timeout got no rsp_stb want rsp_stb within 50 cycles"); end
    bus.req_stb[1] = 1'b1;
    bus.rsp_ack    = 4'b0010;
    bad_stb = 0;
    bad_z   = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rsp_stb !== 4'b0001) bad_stb++;
      if (bus.rsp_z !== 32'h40A0_0000) bad_z++;
    end
    checks++; if (bad_stb != 0) begin errors++; $display("FAIL delay_rsp_stb_hold got %0d bad cycles want 0", bad_stb); end
    checks++; if (bad_z != 0) begin errors++; $display("FAIL delay_rsp_z_hold got %0d bad cycles want 0", bad_z); end
    checks++; if (zack_cnt != 1) begin errors++; $display("FAIL delay_zack_pulses got %0d want 1", zack_cnt); end
    checks++; if (grants.size() != 1 || busy !== 1'b1) begin
      errors++; $display("FAIL delay_no_grant got grants=%0d busy=%0b want 1 1", grants.size(), busy); end
    bus.rsp_ack = 4'b0001;
    @(negedge clk);
    bus.rsp_ack = 4'b0000;
    checks++; if (op_count !== 16'd1 || bus.rsp_stb !== 4'b0) begin
      errors++; $display("FAIL delay_release got op_count=%0d rsp_stb=%b want 1 0000", op_count, bus.rsp_stb); end
    auto_rsp    = 1'b1;
    core_result = 32'h4000_0000;
    wait_ops(16'd2, 100, ok);
    checks++; if (!ok || grants.size() != 2 || grants[1] != 1 || bus.rsp_z !== 32'h4000_0000) begin
      errors++; $display("FAIL delay_next_grant got grants=%0d rsp_z=%h want 2 grants, 2nd to 1, rsp_z 40000000", grants.size(), bus.rsp_z); end
  endtask

  // Runs straight after test_delayed_ack so registers hold non-reset values.
  task automatic test_reset_mid();
    bit ok;
    int seen;
    core_lat       = 10;
    bus.req_a[127:96] = 32'h4120_0000;
    bus.req_b[127:96] = 32'h4130_0000;
    bus.req_stb[3] = 1'b1;
    wait_grants(3, 50, ok);
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1 || bus.core_in_stb !== 1'b0 || owner !== 2'd3) begin
      errors++; $display("FAIL midrst_pre got busy=%0b in_stb=%0b owner=%0d want 1 0 3", busy, bus.core_in_stb, owner); end
    #2;
    rstnn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || owner !== 2'd0 || op_count !== 16'd0) begin
      errors++; $display("FAIL midrst_status got busy=%0b owner=%0d op_count=%0d want 0 0 0", busy, owner, op_count); end
    checks++; if (bus.rsp_z !== 32'h0 || bus.rsp_stb !== 4'b0 || bus.req_ack !== 4'b0) begin
      errors++; $display("FAIL midrst_rsp got rsp_z=%h rsp_stb=%b req_ack=%b want 0", bus.rsp_z, bus.rsp_stb, bus.req_ack); end
    checks++; if (bus.core_a !== 32'h0 || bus.core_b !== 32'h0 || bus.core_in_stb !== 1'b0 || bus.core_z_ack !== 1'b0) begin
      errors++; $display("FAIL midrst_core got a=%h b=%h in_stb=%0b z_ack=%0b want 0", bus.core_a, bus.core_b, bus.core_in_stb, bus.core_z_ack); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.rsp_stb != '0) seen++;
    end
    checks++; if (seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_after got rsp_stb cycles=%0d busy=%0b want 0 0", seen, busy); end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    core_result = 32'h3F80_0000;
    @(negedge clk);
    force dut.op_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_count_q;
    bus.req_stb[2] = 1'b1;
    wait_ops(16'hFFFF, 100, ok);
    checks++; if (op_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff got %h want ffff", op_count); end
    bus.req_stb[2] = 1'b1;
    wait_ops(16'h0000, 100, ok);
    checks++; if (!ok || op_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", op_count); end
    checks++; if (grants.size() != 2) begin errors++; $display("FAIL wrap_grants got %0d want 2", grants.size()); end
  endtask

  task automatic test_onehot();
    bit ok;
    do_reset();
    core_result = 32'h4000_0000;
    bus.req_stb = 4'b1011;
    wait_ops(16'd3, 200, ok);
    checks++; if (!ok || onehot_err != 0 || long_ack != 0) begin
      errors++; $display("FAIL onehot got ops_done=%0b onehot_err=%0d long_ack=%0d want 1 0 0", ok, onehot_err, long_ack); end
  endtask

  initial begin
    rstnn       = 1'b0;
    bus.req_stb = '0;
    bus.rsp_ack = '0;
    bus.req_a   = '0;
    bus.req_b   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_priority();
    test_delayed_ack();
    test_reset_mid();
    test_wrap();
    test_onehot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
